pkt_stream_gen: RTL and testbench

//  Packet source for the user data path. Emits framed packets on the out_data/out_ctrl/out_wr/out_rdy stream.

---
 rtl/pkt_stream_if.sv | 12 +
 rtl/pkt_stream_gen.sv | 150 +++++++++++++++
 tb/tb_pkt_stream_gen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pkt_stream_if.sv
// pkt_stream_if: framed 64-bit packet stream with a write-qualify/ready handshake.
interface pkt_stream_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic                  out_wr;
  logic                  out_rdy;
  modport master (output out_data, output out_ctrl, output out_wr, input out_rdy);
  modport slave (input out_data, input out_ctrl, input out_wr, output out_rdy);
endinterface

// File: rtl/pkt_stream_gen.sv
// pkt_stream_gen: framed packet source with optional pattern injection at a chosen word index.
module pkt_stream_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int MIN_BYTES  = 60,
  parameter int MAX_BYTES  = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gen_en_i,
  input  logic [15:0] pkt_len_bytes_i,
  input  logic [15:0] num_pkts_i,
  input  logic [7:0]  gap_cycles_i,
  input  logic [15:0] dst_port_i,
  input  logic [15:0] src_port_i,
  input  logic        inject_en_i,
  input  logic [10:0] inject_idx_i,
  input  logic [63:0] inject_pattern_i,
  pkt_stream_if.master out_if,
  output logic        busy_o,
  output logic        run_done_o,
  output logic [31:0] pkts_sent_o
);
  localparam logic [15:0] MIN_L = 16'(MIN_BYTES);
  localparam logic [15:0] MAX_L = 16'(MAX_BYTES);
  typedef enum logic [2:0] {IDLE, HDR, BODY, GAP, HALT} state_t;
  typedef struct packed {
    logic [15:0] len;
    logic [11:0] w;
    logic [15:0] num;
    logic [7:0]  gap;
    logic [15:0] dst;
    logic [15:0] src;
    logic        inj;
    logic [10:0] idx;
    logic [63:0] pat;
  } cfg_t;
  state_t                state_q, state_d;
  cfg_t                  cfg_q, cfg_d, cfg_in;
  logic                  valid_q, valid_d, run_done_q, run_done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [11:0]           wc_q, wc_d, nk;
  logic [7:0]            gcnt_q, gcnt_d;
  logic [15:0]           run_q, run_d, run_nx, l_in;
  logic [31:0]           pkts_q, pkts_d;
  logic [2:0]            last_sh;
  logic                  xfer, last_x, gap_end, done;
  function automatic logic [63:0] hdr(input cfg_t c);
    return {c.dst, 4'h0, c.w, c.src, c.len};
  endfunction
  assign l_in = pkt_len_bytes_i < MIN_L ? MIN_L : pkt_len_bytes_i > MAX_L ? MAX_L : pkt_len_bytes_i;
  assign cfg_in = '{len: l_in, w: 12'(l_in[15:3]) + 12'(|l_in[2:0]), num: num_pkts_i,
                    gap: gap_cycles_i, dst: dst_port_i, src: src_port_i, inj: inject_en_i,
                    idx: inject_idx_i, pat: inject_pattern_i};
  assign out_if.out_data = data_q;
  assign out_if.out_ctrl = ctrl_q;
  assign out_if.out_wr   = valid_q & out_if.out_rdy;
  assign busy_o          = state_q inside {HDR, BODY, GAP};
  assign run_done_o      = run_done_q;
  assign pkts_sent_o     = pkts_q;
  assign xfer    = valid_q & out_if.out_rdy;
  assign nk      = wc_q + 12'd1;
  assign last_sh = 3'd0 - cfg_q.len[2:0];
  assign last_x  = state_q == BODY && xfer && wc_q == cfg_q.w;
  assign run_nx  = run_q + 16'(last_x);
  assign done    = cfg_q.num != 16'd0 && run_nx == cfg_q.num;
  assign gap_end = (last_x && cfg_q.gap == 8'd0) || (state_q == GAP && gcnt_q == cfg_q.gap - 8'd1);
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    valid_d    = valid_q;
    data_d     = data_q;
    ctrl_d     = ctrl_q;
    wc_d       = wc_q;
    gcnt_d     = gcnt_q;
    run_d      = run_q;
    pkts_d     = pkts_q;
    run_done_d = 1'b0;
    case (state_q)
      IDLE: if (gen_en_i) begin
        state_d = HDR;
        cfg_d   = cfg_in;
        wc_d    = '0;
      end
      HDR: if (!valid_q) begin
        valid_d = 1'b1;
        data_d  = hdr(cfg_q);
        ctrl_d  = 8'hFF;
      end else if (xfer) state_d = BODY;
      BODY: if (last_x) begin
        state_d = GAP;
        valid_d = 1'b0;
        pkts_d  = pkts_q + 32'd1;
        run_d   = run_nx;
        gcnt_d  = '0;
      end
      GAP: gcnt_d = gcnt_q + 8'd1;
      HALT: if (!gen_en_i) begin
        state_d = IDLE;
        run_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    // header transfer and every non-final body transfer load the next payload word
    if (xfer && (state_q == HDR || (state_q == BODY && !last_x))) begin
      wc_d   = nk;
      data_d = cfg_q.inj && {1'b0, cfg_q.idx} == nk ? cfg_q.pat : {pkts_q, 16'h0, 4'h0, nk};
      ctrl_d = nk == cfg_q.w ? 8'd1 << last_sh : 8'h00;
    end
    if (gap_end) begin
      if (done) begin
        state_d    = HALT;
        run_done_d = 1'b1;
      end else if (gen_en_i) begin
        state_d = HDR;
        cfg_d   = cfg_in;
        valid_d = 1'b1;
        data_d  = hdr(cfg_in);
        ctrl_d  = 8'hFF;
        wc_d    = '0;
      end else state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      ctrl_q     <= '0;
      wc_q       <= '0;
      gcnt_q     <= '0;
      run_q      <= '0;
      pkts_q     <= '0;
      run_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      wc_q       <= wc_d;
      gcnt_q     <= gcnt_d;
      run_q      <= run_d;
      pkts_q     <= pkts_d;
      run_done_q <= run_done_d;
    end
  end
endmodule

// File: tb/tb_pkt_stream_gen.sv
// tb_pkt_stream_gen: directed checks of framing, clamping, injection, backpressure, gaps and reset.
module tb_pkt_stream_gen;
  logic        clk = 0, reset = 1, gen_en = 0, inj_en = 0, busy, run_done;
  logic [15:0] len = 16'd64, num = 16'd1, dst = 16'hAAAA, src = 16'h5555;
  logic [7:0]  gap = 0;
  logic [10:0] idx = 0;
  logic [63:0] pat = 0;
  logic [31:0] pkts_sent;
  int compared = 0, mismatched = 0, rd_cnt = 0, viol = 0, cyc = 0, hits = 0, bad = 0;
  bit rand_rdy = 0;
  typedef struct {logic [63:0] d; logic [7:0] c; int t;} rec_t;
  rec_t rx[$];
  pkt_stream_if sif ();
  pkt_stream_gen dut (
    .clk(clk), .reset(reset), .gen_en_i(gen_en), .pkt_len_bytes_i(len), .num_pkts_i(num),
    .gap_cycles_i(gap), .dst_port_i(dst), .src_port_i(src), .inject_en_i(inj_en),
    .inject_idx_i(idx), .inject_pattern_i(pat), .out_if(sif), .busy_o(busy),
    .run_done_o(run_done), .pkts_sent_o(pkts_sent)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sif.out_wr) rx.push_back('{sif.out_data, sif.out_ctrl, cyc});
    if (sif.out_wr && !sif.out_rdy) viol++;
    if (run_done) rd_cnt++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && !run_done; i++) begin
      step();
      if (rand_rdy) sif.out_rdy = 1'($urandom_range(0, 1));
    end
    chk({tag, "_done"}, run_done, 1);
    sif.out_rdy = 1;
    gen_en = 0;
    repeat (3) step();
  endtask
  task automatic wait_rx(input string tag, input int n);
    for (int i = 0; i < 500 && rx.size() < n; i++) step();
    chk({tag, "_rx"}, rx.size() >= n, 1);
  endtask
  task automatic check_stream(input string tag, input int l_raw, input int p0, input int n,
                              input bit inj, input int ix, input logic [63:0] ip);
    int l, w, pos, errs;
    logic [63:0] ed;
    logic [7:0] ec;
    l = l_raw < 60 ? 60 : l_raw > 2048 ? 2048 : l_raw;
    w = (l + 7) / 8;
    pos = 0;
    errs = 0;
    for (int p = 0; p < n; p++)
      for (int k = 0; k <= w; k++) begin
        ec = k == 0 ? 8'hFF : k == w ? 8'h80 >> ((l - 1) % 8) : 8'h00;
        ed = k == 0 ? {dst, 16'(w), src, 16'(l)} : (inj && k == ix) ? ip : {32'(p0 + p), 16'h0, 16'(k)};
        if (pos >= rx.size() || rx[pos].d !== ed || rx[pos].c !== ec) errs++;
        pos++;
      end
    chk({tag, "_len"}, rx.size(), pos);
    chk({tag, "_words"}, errs, 0);
  endtask
  initial begin
    sif.out_rdy = 1;
    repeat (2) step();
    chk("rst_wr", sif.out_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", run_done, 0);
    chk("rst_pkts", pkts_sent, 0);
    chk("rst_data", sif.out_data, 0);
    chk("rst_ctrl", sif.out_ctrl, 0);
    reset = 0;
    step();
    rx.delete();
    rd_cnt = 0;
    gen_en = 1;
    step();
    chk("t1_lat1", sif.out_wr, 0);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_lat2", sif.out_wr, 1);
    chk("t1_hdr", sif.out_data, 64'hAAAA_0008_5555_0040);
    wait_done("t1");
    chk("t1_n", rx.size(), 9);
    bad = 0;
    for (int k = 0; k < 9; k++)
      if (k >= rx.size() || rx[k].c !== (k == 0 ? 8'hFF : k == 8 ? 8'h01 : 8'h00)) bad++;
    chk("t1_ctrl", bad, 0);
    chk("t1_w1", rx[1].d, 64'h0000_0000_0000_0001);
    chk("t1_rd", rd_cnt, 1);
    chk("t1_pkts", pkts_sent, 1);
    chk("t1_idle", busy, 0);
    rx.delete();
    len = 61;
    gen_en = 1;
    wait_done("t2a");
    chk("t2a_last", rx[8].c, 8'h08);
    check_stream("t2a", 61, 1, 1, 0, 0, 0);
    rx.delete();
    len = 10;
    gen_en = 1;
    wait_done("t2b");
    chk("t2b_hdr", rx[0].d, 64'hAAAA_0008_5555_003C);
    chk("t2b_last", rx[8].c, 8'h10);
    check_stream("t2b", 10, 2, 1, 0, 0, 0);
    rx.delete();
    len = 64;
    inj_en = 1;
    idx = 5;
    pat = 64'h7F00_0000_0000_0007;
    gen_en = 1;
    wait_done("t3a");
    chk("t3a_hit", rx[5].d, 64'h7F00_0000_0000_0007);
    chk("t3a_w4", rx[4].d, 64'h0000_0003_0000_0004);
    chk("t3a_w6", rx[6].d, 64'h0000_0003_0000_0006);
    check_stream("t3a", 64, 3, 1, 1, 5, 64'h7F00_0000_0000_0007);
    rx.delete();
    idx = 9;
    gen_en = 1;
    wait_done("t3b");
    hits = 0;
    foreach (rx[i]) if (rx[i].d === 64'h7F00_0000_0000_0007) hits++;
    chk("t3b_hits", hits, 0);
    chk("t3b_w8", rx[8].d, 64'h0000_0004_0000_0008);
    inj_en = 0;
    rx.delete();
    viol = 0;
    rd_cnt = 0;
    len = 100;
    num = 20;
    gap = 1;
    rand_rdy = 1;
    gen_en = 1;
    wait_done("t4");
    rand_rdy = 0;
    check_stream("t4", 100, 5, 20, 0, 0, 0);
    chk("t4_viol", viol, 0);
    chk("t4_rd", rd_cnt, 1);
    chk("t4_pkts", pkts_sent, 25);
    rx.delete();
    len = 64;
    num = 0;
    gap = 3;
    gen_en = 1;
    wait_rx("t5", 12);
    gen_en = 0;
    repeat (40) step();
    chk("t5_n", rx.size(), 18);
    chk("t5_gap", rx[9].t - rx[8].t, 4);
    chk("t5_hdr2", rx[9].c, 8'hFF);
    chk("t5_last", rx[17].c, 8'h01);
    chk("t5_busy", busy, 0);
    chk("t5_pkts", pkts_sent, 27);
    rx.delete();
    gap = 0;
    gen_en = 1;
    wait_rx("t6a", 4);
    reset = 1;
    #1;
    chk("t6_wr", sif.out_wr, 0);
    chk("t6_pkts_rst", pkts_sent, 0);
    chk("t6_busy", busy, 0);
    step();
    rx.delete();
    reset = 0;
    wait_rx("t6b", 1);
    chk("t6_ctrl", rx[0].c, 8'hFF);
    chk("t6_data", rx[0].d, 64'hAAAA_0008_5555_0040);
    chk("t6_pkts", pkts_sent, 0);
    gen_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
